// File: rtl/jt900h_flags_pkg.sv
// Shared definitions for the TLCS-900H flag stage: F bit positions, update
// mask bit order, carry-op and condition-code encodings, plus helpers that
// build the next F value.
package jt900h_flags_pkg;

  // F register bit positions; bits 5 and 3 are unimplemented and read 0
  localparam int S_FLAG = 7;
  localparam int Z_FLAG = 6;
  localparam int H_FLAG = 4;
  localparam int V_FLAG = 2;
  localparam int N_FLAG = 1;
  localparam int C_FLAG = 0;
  localparam logic [7:0] F_IMPL = 8'hD7;

  // fmask bit order {S,Z,H,V,N,C}
  localparam int FM_S = 5;
  localparam int FM_Z = 4;
  localparam int FM_H = 3;
  localparam int FM_V = 2;
  localparam int FM_N = 1;
  localparam int FM_C = 0;

  typedef enum logic [2:0] {
    NONE_CF = 3'd0,
    SCF_CF  = 3'd1,
    RCF_CF  = 3'd2,
    CCF_CF  = 3'd3,
    ZCF_CF  = 3'd4
  } cf_op_e;

  // 8-15 are the complements of 0-7
  typedef enum logic [3:0] {
    CC_F, CC_LT, CC_LE, CC_ULE, CC_OV, CC_MI, CC_Z, CC_ULT,
    CC_T, CC_GE, CC_GT, CC_UGT, CC_NOV, CC_PL, CC_NZ, CC_NC
  } cc_e;

  typedef enum logic {ST_IDLE, ST_WAIT} state_e;

  // per-commit control, latched while the divider is busy
  typedef struct packed {
    logic [5:0] fmask;
    logic       n_val;
    logic       pv_sel;
  } commit_ctl_t;

  typedef struct packed {
    logic s, z, h, v, p, c;
  } alu_flags_t;

  function automatic logic [7:0] cf_apply(input logic [7:0] f, input logic [2:0] op);
    logic [7:0] r;
    r = f;
    case (op)
      SCF_CF: begin r[C_FLAG] = 1'b1;       r[H_FLAG] = 1'b0; r[N_FLAG] = 1'b0; end
      RCF_CF: begin r[C_FLAG] = 1'b0;       r[H_FLAG] = 1'b0; r[N_FLAG] = 1'b0; end
      CCF_CF: begin r[C_FLAG] = ~f[C_FLAG]; r[N_FLAG] = 1'b0; end
      ZCF_CF: begin r[C_FLAG] = ~f[Z_FLAG]; r[N_FLAG] = 1'b0; end
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] commit_apply(input logic [7:0] f, input commit_ctl_t ctl,
                                              input alu_flags_t a);
    logic [7:0] r;
    r = f;
    if (ctl.fmask[FM_S]) r[S_FLAG] = a.s;
    if (ctl.fmask[FM_Z]) r[Z_FLAG] = a.z;
    if (ctl.fmask[FM_H]) r[H_FLAG] = a.h;
    if (ctl.fmask[FM_V]) r[V_FLAG] = ctl.pv_sel ? a.p : a.v;
    if (ctl.fmask[FM_N]) r[N_FLAG] = ctl.n_val;
    if (ctl.fmask[FM_C]) r[C_FLAG] = a.c;
    return r;
  endfunction

endpackage

// File: rtl/jt900h_flags_cc.sv
// Combinational condition evaluator.
//   cc    : 4-bit condition code (bit 3 inverts the base condition)
//   flags : F register
//   cc_ok : condition true
module jt900h_flags_cc
  import jt900h_flags_pkg::*;
(
  input  logic [3:0] cc,
  input  logic [7:0] flags,
  output logic       cc_ok
);

  logic lt, base;
  logic unused_bits;

  assign unused_bits = ^{flags[5], flags[H_FLAG], flags[3], flags[N_FLAG]};
  assign lt          = flags[S_FLAG] ^ flags[V_FLAG];

  always_comb begin
    base = 1'b0;
    case (cc[2:0])
      3'd0: base = 1'b0;
      3'd1: base = lt;
      3'd2: base = lt | flags[Z_FLAG];
      3'd3: base = flags[C_FLAG] | flags[Z_FLAG];
      3'd4: base = flags[V_FLAG];
      3'd5: base = flags[S_FLAG];
      3'd6: base = flags[Z_FLAG];
      3'd7: base = flags[C_FLAG];
      default: base = 1'b0;
    endcase
  end

  assign cc_ok = base ^ cc[3];

endmodule

// File: rtl/jt900h_flags.sv
// TLCS-900H flag register stage. Captures masked ALU flags into F, holds the
// alternate bank F', executes SCF/RCF/CCF/ZCF, EX F,F' and F loads, and
// defers a commit while the divider is busy.
//   clk/rst/cen           : clock, sync active-high reset, clock enable
//   alu_*                 : ALU flag outputs
//   n_val/pv_sel/fmask    : per-instruction commit control
//   commit/div_busy       : commit strobe, divider busy
//   cf_op/ex_ff/ld_f/din  : carry ops, bank swap, direct load
//   cc/cc_ok              : condition evaluation on current F
//   flags/flags_alt       : F, F'
//   nout/hout/cout/zout   : F bits fed back to the ALU
//   pend                  : commit waiting for the divider
module jt900h_flags
  import jt900h_flags_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       cen,
  input  logic       alu_s,
  input  logic       alu_z,
  input  logic       alu_h,
  input  logic       alu_v,
  input  logic       alu_p,
  input  logic       alu_c,
  input  logic       n_val,
  input  logic       pv_sel,
  input  logic [5:0] fmask,
  input  logic       commit,
  input  logic       div_busy,
  input  logic [2:0] cf_op,
  input  logic       ex_ff,
  input  logic       ld_f,
  input  logic [7:0] din,
  input  logic [3:0] cc,
  output logic [7:0] flags,
  output logic [7:0] flags_alt,
  output logic       nout,
  output logic       hout,
  output logic       cout,
  output logic       zout,
  output logic       cc_ok,
  output logic       pend
);

  state_e      state, state_nx;
  commit_ctl_t ctl_q, ctl_in, ctl_use;
  alu_flags_t  alu;
  logic [7:0]  f, f_alt, f_base, f_new, f_nx, f_alt_nx;
  logic        do_commit, latch_ctl;

  assign ctl_in = '{fmask: fmask, n_val: n_val, pv_sel: pv_sel};
  assign alu    = '{s: alu_s, z: alu_z, h: alu_h, v: alu_v, p: alu_p, c: alu_c};

  always_comb begin
    state_nx  = state;
    do_commit = 1'b0;
    latch_ctl = 1'b0;
    ctl_use   = ctl_in;
    case (state)
      ST_IDLE: if (commit) begin
        if (div_busy) begin
          state_nx  = ST_WAIT;
          latch_ctl = 1'b1;
        end else begin
          do_commit = 1'b1;
        end
      end
      ST_WAIT: begin
        // new commit strobes are ignored; the latched masks meet this cycle's ALU flags
        ctl_use = ctl_q;
        if (!div_busy) begin
          do_commit = 1'b1;
          state_nx  = ST_IDLE;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    f_base = ld_f ? (din & F_IMPL) : cf_apply(f, cf_op);
    f_new  = do_commit ? (commit_apply(f_base, ctl_use, alu) & F_IMPL) : f_base;
    // swap is applied last so F' receives the fully built value
    f_nx     = ex_ff ? f_alt : f_new;
    f_alt_nx = ex_ff ? f_new : f_alt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      ctl_q <= '0;
      f     <= '0;
      f_alt <= '0;
    end else if (cen) begin
      state <= state_nx;
      if (latch_ctl) ctl_q <= ctl_in;
      f     <= f_nx;
      f_alt <= f_alt_nx;
    end
  end

  jt900h_flags_cc u_cc (
    .cc    (cc),
    .flags (f),
    .cc_ok (cc_ok)
  );

  assign flags     = f;
  assign flags_alt = f_alt;
  assign nout      = f[N_FLAG];
  assign hout      = f[H_FLAG];
  assign cout      = f[C_FLAG];
  assign zout      = f[Z_FLAG];
  assign pend      = (state == ST_WAIT);

endmodule

// File: tb/tb_jt900h_flags.sv
module tb_jt900h_flags;

  logic       clk = 1'b0;
  logic       rst, cen;
  logic       alu_s, alu_z, alu_h, alu_v, alu_p, alu_c;
  logic       n_val, pv_sel, commit, div_busy, ex_ff, ld_f;
  logic [5:0] fmask;
  logic [2:0] cf_op;
  logic [7:0] din;
  logic [3:0] cc;
  logic [7:0] flags, flags_alt;
  logic       nout, hout, cout, zout, cc_ok, pend;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  jt900h_flags dut (
    .clk(clk), .rst(rst), .cen(cen),
    .alu_s(alu_s), .alu_z(alu_z), .alu_h(alu_h), .alu_v(alu_v), .alu_p(alu_p), .alu_c(alu_c),
    .n_val(n_val), .pv_sel(pv_sel), .fmask(fmask), .commit(commit), .div_busy(div_busy),
    .cf_op(cf_op), .ex_ff(ex_ff), .ld_f(ld_f), .din(din), .cc(cc),
    .flags(flags), .flags_alt(flags_alt), .nout(nout), .hout(hout), .cout(cout), .zout(zout),
    .cc_ok(cc_ok), .pend(pend)
  );

  // one cycle of stimulus: alu = {s,z,h,v,p,c}
  typedef struct {
    string      name;
    logic       ld;
    logic [7:0] d;
    logic [2:0] cf;
    logic       cm;
    logic [5:0] fm;
    logic [5:0] alu;
    logic       nv;
    logic       pv;
    logic       ex;
    logic [3:0] cc;
    logic [7:0] exp_f;
    logic [7:0] exp_alt;
    logic       exp_ok;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_in();
    {alu_s, alu_z, alu_h, alu_v, alu_p, alu_c} = '0;
    n_val = 0; pv_sel = 0; fmask = '0; commit = 0; div_busy = 0;
    cf_op = '0; ex_ff = 0; ld_f = 0; din = '0; cc = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input string nm, input logic ld, input logic [7:0] d, input logic [2:0] cf,
                     input logic cm, input logic [5:0] fm, input logic [5:0] a, input logic nv,
                     input logic pv, input logic ex, input logic [3:0] c,
                     input logic [7:0] ef, input logic [7:0] ea, input logic eo);
    vec_t v;
    v = '{name: nm, ld: ld, d: d, cf: cf, cm: cm, fm: fm, alu: a, nv: nv, pv: pv, ex: ex,
          cc: c, exp_f: ef, exp_alt: ea, exp_ok: eo};
    vt.push_back(v);
  endtask

  initial begin
    // name           ld  din    cf  cm fmask      alu szhvpc nv pv ex cc     F      F'     ok
    add("commit_all", 0, 8'h00, 0, 1, 6'b111111, 6'b101101, 1, 0, 0, 4'd1,  8'h97, 8'h00, 0);
    add("mi",         0, 8'h00, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd5,  8'h97, 8'h00, 1);
    add("commit_c",   0, 8'h00, 0, 1, 6'b000001, 6'b000000, 0, 0, 0, 4'd7,  8'h96, 8'h00, 0);
    add("commit_pv",  0, 8'h00, 0, 1, 6'b000100, 6'b000100, 0, 1, 0, 4'd4,  8'h92, 8'h00, 0);
    add("ld_41",      1, 8'h41, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd6,  8'h41, 8'h00, 1);
    add("zcf",        0, 8'h00, 4, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd14, 8'h40, 8'h00, 0);
    add("ccf",        0, 8'h00, 3, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd15, 8'h41, 8'h00, 0);
    add("ld_53",      1, 8'h53, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd3,  8'h53, 8'h00, 1);
    add("scf",        0, 8'h00, 1, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd11, 8'h41, 8'h00, 0);
    add("rcf",        0, 8'h00, 2, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd2,  8'h40, 8'h00, 1);
    add("ld_80",      1, 8'h80, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd0,  8'h80, 8'h00, 0);
    add("ex_1",       0, 8'h00, 0, 0, 6'b000000, 6'b000000, 0, 0, 1, 4'd8,  8'h00, 8'h80, 1);
    add("ld_01",      1, 8'h01, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd7,  8'h01, 8'h80, 1);
    add("ex_commit",  0, 8'h00, 0, 1, 6'b000001, 6'b000000, 0, 0, 1, 4'd9,  8'h80, 8'h00, 0);
    add("ld_scf",     1, 8'hFF, 1, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd8,  8'hD7, 8'h00, 1);
    add("cf_bad",     0, 8'h00, 5, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd10, 8'hD7, 8'h00, 0);
    add("pl",         0, 8'h00, 0, 0, 6'b000000, 6'b000000, 0, 0, 0, 4'd13, 8'hD7, 8'h00, 0);
    add("ld_commit",  1, 8'h00, 0, 1, 6'b010000, 6'b010000, 0, 0, 0, 4'd14, 8'h40, 8'h00, 0);

    idle_in();
    cen = 1; rst = 1;
    step(); step();
    chk("rst_flags", flags, 8'h00);
    chk("rst_alt", flags_alt, 8'h00);
    chk("rst_pend", pend, 1'b0);
    rst = 0;

    foreach (vt[i]) begin
      idle_in();
      ld_f = vt[i].ld; din = vt[i].d; cf_op = vt[i].cf; commit = vt[i].cm;
      fmask = vt[i].fm; {alu_s, alu_z, alu_h, alu_v, alu_p, alu_c} = vt[i].alu;
      n_val = vt[i].nv; pv_sel = vt[i].pv; ex_ff = vt[i].ex; cc = vt[i].cc;
      step();
      chk({vt[i].name, ".f"}, flags, vt[i].exp_f);
      chk({vt[i].name, ".alt"}, flags_alt, vt[i].exp_alt);
      chk({vt[i].name, ".cc_ok"}, cc_ok, vt[i].exp_ok);
      chk({vt[i].name, ".fb"}, {nout, hout, cout, zout},
          {vt[i].exp_f[1], vt[i].exp_f[4], vt[i].exp_f[0], vt[i].exp_f[6]});
      chk({vt[i].name, ".pend"}, pend, 1'b0);
    end

    // deferred commit: mask V only, latched; live inputs change during the wait
    idle_in(); ld_f = 1; din = 8'h00; step();
    idle_in(); commit = 1; fmask = 6'b000100; div_busy = 1; step();
    chk("wait0.pend", pend, 1'b1);
    chk("wait0.f", flags, 8'h00);
    for (int k = 1; k < 5; k++) begin
      idle_in(); div_busy = 1; fmask = 6'b111111; alu_v = 1; alu_s = 1;
      if (k == 2) commit = 1;
      step();
      chk($sformatf("wait%0d.pend", k), pend, 1'b1);
      chk($sformatf("wait%0d.f", k), flags, 8'h00);
    end
    idle_in(); div_busy = 0; fmask = 6'b111111; alu_v = 1; alu_s = 1; alu_c = 1; step();
    chk("wait_done.f", flags, 8'h04);
    chk("wait_done.pend", pend, 1'b0);
    idle_in(); alu_s = 1; step();
    chk("wait_after.f", flags, 8'h04);

    // cen low: strobes lost, state frozen
    idle_in(); cen = 0; ld_f = 1; din = 8'hFF; ex_ff = 1; step();
    chk("cen0.f", flags, 8'h04);
    chk("cen0.alt", flags_alt, 8'h00);
    cen = 1;

    // reset during WAIT discards the pending commit
    idle_in(); ld_f = 1; din = 8'hD7; ex_ff = 1; step();
    idle_in(); ld_f = 1; din = 8'hD7; step();
    idle_in(); commit = 1; fmask = 6'b111111; div_busy = 1; step();
    chk("rstw.pend_before", pend, 1'b1);
    idle_in(); div_busy = 1; rst = 1; step();
    chk("rstw.f", flags, 8'h00);
    chk("rstw.alt", flags_alt, 8'h00);
    chk("rstw.pend", pend, 1'b0);
    rst = 0;
    idle_in(); {alu_s, alu_z, alu_h, alu_v, alu_p, alu_c} = 6'b111111; step(); step();
    chk("rstw.no_late.f", flags, 8'h00);
    chk("rstw.no_late.pend", pend, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
